// File: rtl/code_event_logger_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | code_event_logger_if : capture, drain and status bundle.            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface code_event_logger_if #(
  parameter int DEPTH  = 8,
  parameter int CODE_W = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [31:0]       count;
  logic              event_valid;
  logic [CODE_W-1:0] event_code;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_stamp;
  logic [CODE_W-1:0] out_code;
  logic [LW-1:0]     level;
  logic [15:0]       drop_count;
  logic              overflow;

  modport master (
    output count, event_valid, event_code, clear, out_ready,
    input  out_valid, out_stamp, out_code, level, drop_count, overflow
  );

  modport slave (
    input  count, event_valid, event_code, clear, out_ready,
    output out_valid, out_stamp, out_code, level, drop_count, overflow
  );
endinterface
`default_nettype wire

// File: rtl/code_event_logger.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | code_event_logger : timestamped event FIFO with drop statistics.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module code_event_logger #(
  parameter int DEPTH  = 8,
  parameter int CODE_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  code_event_logger_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 32 + CODE_W;
  localparam logic [LW-1:0] c_FULL_LEVEL = LW'(DEPTH);

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [15:0]   r_drop_count;
  logic          r_overflow;

  logic          w_out_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [EW-1:0] w_head;

  assign w_out_valid = (r_level != '0);
  assign w_pop       = w_out_valid & bus.out_ready;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign w_push      = bus.event_valid & ((r_level != c_FULL_LEVEL) | w_pop);
  assign w_drop      = bus.event_valid & ~w_push;
  assign w_head      = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push && !bus.clear) begin
      r_mem[r_wr_ptr] <= {bus.count, bus.event_code};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
    end else if (bus.clear) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF) begin
          r_drop_count <= r_drop_count + 16'd1;
        end
      end
    end
  end

  assign bus.out_valid  = w_out_valid;
  assign bus.out_stamp  = w_out_valid ? w_head[EW-1:CODE_W] : 32'd0;
  assign bus.out_code   = w_out_valid ? w_head[CODE_W-1:0] : '0;
  assign bus.level      = r_level;
  assign bus.drop_count = r_drop_count;
  assign bus.overflow   = r_overflow;
endmodule
`default_nettype wire
